vram_write_queue: RTL and testbench
===================================

VRAM_WRITE_QUEUE -- requirements
Module: vram_write_queue

Interface
REQ-001 Parameter ADDR_W, default 11: framebuffer byte-address width (2048 bytes).
REQ-002 Parameter DATA_W, default 8: framebuffer data width; matches the JML-8 data bus.
REQ-003 Parameter DEPTH, default 16: write-FIFO depth in entries; a power of two, minimum 2.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  pixel clock; same clock as the VGA signal generator.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 wr_valid  in  1  host write request.
REQ-008 wr_ready  out  1  queue can accept an entry.
REQ-009 wr_addr  in  ADDR_W  host framebuffer byte address.
REQ-010 wr_data  in  DATA_W  host write data.
REQ-011 clr_req  in  1  single-cycle pulse requesting a full-framebuffer clear to zero.
REQ-012 visible  in  1  active-video flag from the signal generator; high means the framebuffer read port is in use.
REQ-013 ram_we  out  1  framebuffer write enable.
REQ-014 ram_addr  out  ADDR_W  framebuffer write address.
REQ-015 ram_wdata  out  DATA_W  framebuffer write data.
REQ-016 busy  out  1  clear pending or in progress.
REQ-017 fifo_count  out  clog2(DEPTH+1)  number of queued entries.

Function
REQ-018 A host entry SHALL be accepted on a rising clk edge where wr_valid and wr_ready are both high.
REQ-019 wr_ready = (fifo_count != DEPTH) and SHALL be derived only from registered state.
REQ-020 The block SHALL never assert ram_we in a cycle where visible is high; all framebuffer writes occur during blanking.
REQ-021 ram_we, ram_addr and ram_wdata SHALL be registered; at most one write per cycle.
REQ-022 Entries SHALL be written to RAM in acceptance order, with no loss and no duplication.
REQ-023 Minimum latency SHALL be 1 cycle: an entry accepted at edge N, with visible low at that edge, appears on the RAM port after edge N+1.
REQ-024 On an empty FIFO, a push and a pop SHALL NOT occur at the same edge. On a full FIFO, a pop at edge N SHALL raise wr_ready after edge N.
REQ-025 The FSM SHALL have the states IDLE, PEND and CLEAR.
REQ-026 IDLE: drain the FIFO; on clr_req go to PEND.
REQ-027 PEND: keep draining the entries that were queued before clr_req; when the FIFO is empty go to CLEAR.
REQ-028 CLEAR: write 0 to addresses 0 through 2^ADDR_W-1, one per blanking cycle; after the write to the last address, return to IDLE.
REQ-029 The clear address counter SHALL pause while visible is high and resume where it stopped.
REQ-030 In PEND and CLEAR, host entries SHALL still be accepted while not full; they are held and written after CLEAR ends.
REQ-031 busy SHALL be high in PEND and CLEAR.
REQ-032 clr_req SHALL be ignored while busy is high.
REQ-033 clr_req and a host push at the same edge: the pushed entry SHALL be written after the clear.
REQ-034 The FIFO read and write pointers SHALL be ADDR-independent counters of clog2(DEPTH) bits that wrap modulo DEPTH.

Reset
REQ-035 Asserting rst_n low SHALL immediately force:
- FSM to IDLE
- FIFO empty, pointers 0, fifo_count = 0
- clear counter 0
- ram_we = 0, ram_addr = 0, ram_wdata = 0
- busy = 0
REQ-036 After reset, wr_ready SHALL be 1.
REQ-037 Reset during CLEAR SHALL abandon the clear; queued entries are discarded.
REQ-038 Deassertion of rst_n is synchronized externally; rst_n is used asynchronously only.

Structure
REQ-039 ADDR_W and DATA_W defaults SHALL live in the shared VGA specs header, alongside the timing constants.
REQ-040 The FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH=ADDR_W+DATA_W and DEPTH), with push, pop, full, empty and count.
REQ-041 vram_write_queue SHALL contain the FSM, the clear counter and the output registers.

Verification
REQ-042 visible=0; push addr 0x005 data 0xA5 -> ram_we pulses once with 0x005/0xA5, exactly one cycle after acceptance.
REQ-043 visible=1; push 16 entries, then a 17th -> wr_ready=0 on the 17th; no ram_we; after visible=0, 16 writes in order, and wr_ready returns 1 cycle after the first pop.
REQ-044 visible toggles 1/0 every 3 cycles during a burst of 40 entries -> ram_we never coincides with visible=1; data order is preserved.
REQ-045 3 entries queued, then clr_req, then 2 more pushes -> 3 entries written, then 2048 zero writes covering 0x000-0x7FF, then the 2 entries; busy is high throughout PEND and CLEAR.
REQ-046 clr_req pulsed again mid-CLEAR -> ignored; exactly 2048 clear writes occur.
REQ-047 rst_n low mid-CLEAR at address 0x300 -> all outputs reach reset values immediately; no further ram_we; after release, wr_ready=1 and fifo_count=0.

Source files
------------

// File: rtl/vram_write_queue_pkg.sv
// rtl/vram_write_queue_pkg.sv - shared VGA framebuffer constants and write-queue types
package vram_write_queue_pkg;

  // Framebuffer geometry shared with the VGA signal generator.
  localparam int VGA_ADDR_W = 11;
  localparam int VGA_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    CLEAR = 2'd2
  } wq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // full/empty come straight from the registered count, so a push into an
  // empty FIFO can never be popped at the same edge.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_q];
  assign count   = count_q;

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/vram_write_queue.sv
// rtl/vram_write_queue.sv - blanking-only framebuffer write queue with full clear
module vram_write_queue
  import vram_write_queue_pkg::*;
#(
  parameter int ADDR_W = VGA_ADDR_W,
  parameter int DATA_W = VGA_DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       clr_req,
  input  logic                       visible,
  output logic                       ram_we,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [DATA_W-1:0]          ram_wdata,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = ADDR_W + DATA_W;

  wq_state_t         state_q;
  wq_state_t         state_d;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic [CW-1:0]     pend_left_q;
  logic [EW-1:0]     fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              clr_wr;
  logic              clr_take;

  assign wr_ready = !fifo_full;
  assign push     = wr_valid && wr_ready;
  assign busy     = (state_q != IDLE);

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({wr_addr, wr_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next state and write selection; visible is sampled at the edge that
  // would launch the write, so nothing is launched during active video.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    clr_wr   = 1'b0;
    clr_take = 1'b0;
    unique case (state_q)
      IDLE: begin
        pop = !fifo_empty && !visible;
        if (clr_req) begin
          state_d  = PEND;
          clr_take = 1'b1;
        end
      end
      PEND: begin
        // Only the entries queued before the clear request are drained here.
        if (pend_left_q == '0) state_d = CLEAR;
        else                   pop     = !visible;
      end
      CLEAR: begin
        clr_wr = !visible;
        if (clr_wr && (clr_cnt_q == '1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Pre-clear entry count and clear address; the address wraps back to 0
  // after the last location so the next clear starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_left_q <= '0;
      clr_cnt_q   <= '0;
    end else begin
      if (clr_take)                     pend_left_q <= fifo_count - CW'(pop);
      else if (state_q == PEND && pop) pend_left_q <= pend_left_q - CW'(1);
      if (clr_wr) clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
    end
  end

  // Registered RAM write port: at most one FIFO entry or clear word per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (pop) begin
      ram_we    <= 1'b1;
      ram_addr  <= fifo_dout[EW-1:DATA_W];
      ram_wdata <= fifo_dout[DATA_W-1:0];
    end else if (clr_wr) begin
      ram_we    <= 1'b1;
      ram_addr  <= clr_cnt_q;
      ram_wdata <= '0;
    end else begin
      ram_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vram_write_queue.sv
// tb/tb_vram_write_queue.sv - scoreboard bench for vram_write_queue
module tb_vram_write_queue;

  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int NCLR  = 2048;

  typedef struct packed {
    logic          host;
    logic          last;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          clr_req;
  logic          visible;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          busy;
  logic [CW-1:0] fifo_count;

  vram_write_queue #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .clr_req    (clr_req),
    .visible    (visible),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model: expected RAM write stream, entries held behind a clear,
  // clear-in-progress flag and host entry bookkeeping.
  exp_t exp_q[$];
  exp_t hold_q[$];
  bit   m_busy;
  int   m_acc;
  int   m_hwr;
  logic vis_q;
  int   checks;
  int   failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Observer: records accepted host entries and accepted clear requests at each edge.
  always @(posedge clk) begin
    exp_t e;
    vis_q = visible;
    if (rst_n) begin
      if (clr_req && !m_busy) begin
        m_busy = 1'b1;
        for (int i = 0; i < NCLR; i++) begin
          e = '{host: 1'b0, last: (i == NCLR - 1), a: AW'(i), d: '0};
          exp_q.push_back(e);
        end
      end
      if (wr_valid && wr_ready) begin
        e = '{host: 1'b1, last: 1'b0, a: wr_addr, d: wr_data};
        if (m_busy) hold_q.push_back(e);
        else        exp_q.push_back(e);
        m_acc++;
      end
    end
  end

  // Monitor: compares every RAM write and the status outputs with the model.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("reset_ram_we", ram_we, 0);
      check("reset_busy", busy, 0);
      check("reset_fifo_count", fifo_count, 0);
    end else begin
      check("we_during_visible", ram_we && vis_q, 0);
      if (ram_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", ram_we, 0);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", ram_addr, e.a);
          check("write_data", ram_wdata, e.d);
          if (e.host) m_hwr++;
          if (e.last) begin
            m_busy = 1'b0;
            while (hold_q.size() > 0) exp_q.push_back(hold_q.pop_front());
          end
        end
      end
      check("busy", busy, m_busy);
      check("fifo_count", fifo_count, m_acc - m_hwr);
      check("wr_ready", wr_ready, (m_acc - m_hwr) != DEPTH);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc;
    int n;
    n        = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    do begin
      acc = wr_ready;
      cyc();
      n++;
    end while (!acc && n < 200);
    wr_valid = 1'b0;
    if (!acc) check("push_timeout", wr_ready, 1);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      visible = ($urandom_range(0, 3) == 0);
      cyc();
      n++;
    end
    visible = 1'b0;
    check(name, busy, 0);
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int  sent;
    int  k;
    bit  acc;
    bit  mid;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    clr_req  = 1'b0;
    visible  = 1'b0;
    repeat (3) cyc();
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    rst_n = 1'b1;
    cyc();
    check("rst_wr_ready", wr_ready, 1);

    // Single write, minimum latency.
    wr_valid = 1'b1;
    wr_addr  = 11'h005;
    wr_data  = 8'hA5;
    check("lat_ready", wr_ready, 1);
    cyc();
    wr_valid = 1'b0;
    check("lat_not_yet", ram_we, 0);
    cyc();
    check("lat_we", ram_we, 1);
    check("lat_addr", ram_addr, 11'h005);
    check("lat_data", ram_wdata, 8'hA5);
    cyc();
    check("lat_single", ram_we, 0);

    // Fill during active video, reject the 17th, then drain in blanking.
    visible = 1'b1;
    cyc();
    for (int i = 0; i < DEPTH; i++) push_one(AW'($urandom), DW'($urandom));
    wr_valid = 1'b1;
    wr_addr  = AW'($urandom);
    wr_data  = DW'($urandom);
    check("full_ready", wr_ready, 0);
    check("full_count", fifo_count, DEPTH);
    cyc();
    wr_valid = 1'b0;
    check("full_no_write", ram_we, 0);
    visible = 1'b0;
    cyc();
    check("full_first_pop", ram_we, 1);
    check("full_ready_back", wr_ready, 1);
    repeat (20) cyc();

    // 40-entry burst with visible toggling every 3 cycles.
    sent = 0;
    k    = 0;
    while (sent < 40 && k < 400) begin
      visible  = ((k / 3) % 2) == 0;
      wr_valid = 1'b1;
      wr_addr  = AW'($urandom);
      wr_data  = DW'($urandom);
      acc      = wr_ready;
      cyc();
      if (acc) sent++;
      k++;
    end
    wr_valid = 1'b0;
    check("burst_sent", sent, 40);
    visible = 1'b0;
    repeat (60) cyc();

    // Queued entries, clear, entries pushed after the clear request, repeat clr_req mid-clear.
    visible = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) push_one(AW'($urandom), DW'($urandom));
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    check("clr_busy", busy, 1);
    for (int i = 0; i < 2; i++) push_one(AW'($urandom), DW'($urandom));
    k   = 0;
    mid = 1'b0;
    while (busy && k < 8000) begin
      visible = ($urandom_range(0, 3) == 0);
      if (!mid && ram_we && ram_addr >= 11'h400) begin
        clr_req = 1'b1;
        mid     = 1'b1;
      end else begin
        clr_req = 1'b0;
      end
      cyc();
      k++;
    end
    clr_req = 1'b0;
    visible = 1'b0;
    check("clr_done", busy, 0);
    check("clr_mid_pulse", mid, 1);
    repeat (20) cyc();

    // Random traffic with one clear request in the middle.
    for (int i = 0; i < 500; i++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = AW'($urandom);
      wr_data  = DW'($urandom);
      visible  = ($urandom_range(0, 9) < 3);
      clr_req  = (i == 250);
      cyc();
    end
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    wait_idle("rand_clear_done", 8000);
    repeat (40) cyc();

    // Reset in the middle of a clear with held entries.
    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    for (int i = 0; i < 3; i++) push_one(AW'($urandom), DW'($urandom));
    k = 0;
    while (!(busy && ram_we && ram_addr == 11'h300) && k < 4000) begin
      cyc();
      k++;
    end
    check("mid_reached_300", ram_addr, 11'h300);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", ram_we, 0);
    check("mid_rst_addr", ram_addr, 0);
    check("mid_rst_wdata", ram_wdata, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", fifo_count, 0);
    exp_q.delete();
    hold_q.delete();
    m_busy = 1'b0;
    m_acc  = 0;
    m_hwr  = 0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    check("post_rst_ready", wr_ready, 1);
    check("post_rst_count", fifo_count, 0);
    for (int i = 0; i < 2; i++) push_one(AW'($urandom), DW'($urandom));
    repeat (10) cyc();

    check("final_exp_empty", exp_q.size(), 0);
    check("final_hold_empty", hold_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
